clk_rst_sequencer: RTL and testbench
====================================

Name: clk_rst_sequencer

Overview:
- Parametrised PLL supervisor and reset sequencer for the multi-clock top level.
- Runs on the free-running board clock. Drives the PLL reset and watches the PLL lock output.
- After lock has been stable for a set time, releases N per-domain reset lines one at a time, with a gap between each.
- On lock loss, retry timeout or software request, it re-asserts every domain reset and restarts the sequence.

Parameters:
- N_CH, 4, number of sequenced domain resets (>=1).
- PLL_RST_CYCLES, 8, width of the pll_rst pulse in cycles (>=1).
- LOCK_CYCLES, 1024, cycles of continuous sync'd lock needed before release (>=1).
- STAGGER, 16, cycles between successive channel releases (>=1).
- TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the PLL is reset again (>=2).
- CNT_W, 8, width of the saturating event counters.

Ports:
- clk  in  1  free-running input clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock; asynchronous to clk.
- sw_rst_req  in  1  synchronous level request to restart the sequence from the PLL reset.
- pll_rst  out  1  reset to the PLL.
- ch_rst  out  N_CH  per-domain resets, active-high; bit 0 is released first.
- all_ready  out  1  high when every ch_rst bit is low.
- state  out  3  current FSM state, for debug.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses in RELEASE or RUN.
- retry_cnt  out  CNT_W  saturating count of WAIT_LOCK timeouts.

Behaviour:
- Reset values: pll_rst=1, ch_rst=all 1s, all_ready=0, state=PLL_RST, both counters 0, synchroniser flops 0, cnt=0, idx=0.
- Reset takes effect immediately, including mid-sequence.
- pll_locked passes through a 2-flop synchroniser to give locked_s; the FSM uses locked_s only.
- Priority on any edge: reset > sw_rst_req > lock loss > normal transition.
- PLL_RST:
  - pll_rst=1, ch_rst all 1s.
  - cnt counts 0..PLL_RST_CYCLES-1; at the last value go to WAIT_LOCK with cnt=0.
  - sw_rst_req is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s: go to STABLE, cnt=0.
  - Else if cnt==TIMEOUT-1: go to PLL_RST, cnt=0, retry_cnt+1 (saturating).
  - Else cnt+1.
- STABLE:
  - If !locked_s: go to WAIT_LOCK, cnt=0. Not counted as a lock loss.
  - Else if cnt==LOCK_CYCLES-1: go to RELEASE, cnt=0, idx=0.
  - Else cnt+1.
- RELEASE:
  - cnt counts 0..STAGGER-1. At STAGGER-1, clear ch_rst[idx], idx+1, cnt=0.
  - If idx==N_CH-1 on that same edge, go to RUN and set all_ready=1 together with the last ch_rst clear.
- RUN:
  - Hold all_ready=1, ch_rst=0.
- Lock loss (!locked_s in RELEASE or RUN):
  - On that edge: ch_rst=all 1s, all_ready=0, lock_loss_cnt+1 (saturating), go to WAIT_LOCK, cnt=0.
  - pll_rst is not pulsed.
- sw_rst_req in WAIT_LOCK, STABLE, RELEASE or RUN:
  - On that edge: go to PLL_RST, cnt=0, ch_rst=all 1s, all_ready=0.
  - No counters increment, even if lock loss occurs on the same edge.
- Latency:
  - pll_locked rise to STABLE entry: at most 3 edges (2 synchroniser + 1).
  - STABLE entry to ch_rst[0] low: LOCK_CYCLES+STAGGER edges.
  - ch_rst[i] to ch_rst[i+1]: STAGGER edges.
  - pll_locked fall in RUN to ch_rst all 1s: at most 3 edges.
- Once cleared, ch_rst bits stay low until a re-assert event, so there are no glitches between releases.
- Counter widths are $clog2 of the largest limit. No arithmetic wraps; the event counters hold at 2^CNT_W-1.

Decomposition:
- Shared package clk_rst_pkg holds:
  - state encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4;
  - STATE_W=3.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with async active-high reset to 0. It is reused elsewhere for other asynchronous inputs.

Test Plan:
Bench parameters: N_CH=3, PLL_RST_CYCLES=3, LOCK_CYCLES=8, STAGGER=4, TIMEOUT=20, CNT_W=2.
1. Release reset with pll_locked tied to 1 -> pll_rst high for exactly 3 edges; ch_rst goes 111 -> 110 -> 100 -> 000 at 4-cycle spacing; ch_rst[0] falls 12 edges after state=2; all_ready rises on the same edge as ch_rst[2]; both counters stay 0.
2. pll_locked tied to 0 -> a 3-cycle pll_rst pulse every 23 cycles; retry_cnt goes 1, 2, 3, 3; ch_rst=111 and all_ready=0 throughout.
3. In STABLE, drop pll_locked for 3 cycles and restore -> state 2->1->2; the 8-cycle stability count restarts; lock_loss_cnt stays 0; release timing from the new STABLE entry matches scenario 1.
4. In RUN, drop pll_locked -> within 3 edges ch_rst=111, all_ready=0, lock_loss_cnt=1, pll_rst stays 0; restore lock -> full re-sequence. Repeat 4 more times -> lock_loss_cnt saturates at 3.
5. In RUN, assert sw_rst_req on the same edge locked_s falls -> state=0, pll_rst=1 for 3 edges, lock_loss_cnt unchanged.
6. Assert reset mid-RELEASE with ch_rst=110 -> asynchronously ch_rst=111, pll_rst=1, state=0, both counters 0. Release reset -> the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared state encoding and elaboration helpers for the PLL supervisor / reset sequencer.
package clk_rst_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for stable lock, then releases
// the per-domain resets one by one; re-asserts them on lock loss or request.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PLL_RST   | PLL held in reset for PLL_RST_CYCLES, all domains in reset
//   WAIT_LOCK | PLL running, waiting for lock (retries after TIMEOUT)
//   STABLE    | lock seen, must hold LOCK_CYCLES before any release
//   RELEASE   | domain resets dropped one per STAGGER cycles, bit 0 first
//   RUN       | all domains out of reset
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGGER        = 16,
  parameter int TIMEOUT        = 65536,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic               pll_rst,
  output logic [N_CH-1:0]    ch_rst,
  output logic               all_ready,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   lock_loss_cnt,
  output logic [CNT_W-1:0]   retry_cnt
);
  localparam int MAX_LIM = max4(PLL_RST_CYCLES, LOCK_CYCLES, STAGGER, TIMEOUT);
  localparam int CW      = $clog2(MAX_LIM);
  localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CW-1:0]    PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0]    STG_LAST  = CW'(STAGGER - 1);
  localparam logic [CW-1:0]    TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(N_CH - 1);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  state_t         st;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic           locked_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= PLL_RST;
      cnt           <= '0;
      idx           <= '0;
      pll_rst       <= 1'b1;
      ch_rst        <= '1;
      all_ready     <= 1'b0;
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else if (sw_rst_req && st != PLL_RST) begin
      // a software restart wins over a coincident lock loss and is not counted
      st        <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      ch_rst    <= '1;
      all_ready <= 1'b0;
    end else if (!locked_s && (st == RELEASE || st == RUN)) begin
      st        <= WAIT_LOCK;
      cnt       <= '0;
      ch_rst    <= '1;
      all_ready <= 1'b0;
      if (lock_loss_cnt != EVT_MAX) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end else begin
      case (st)
        PLL_RST: begin
          pll_rst <= 1'b1;
          ch_rst  <= '1;
          if (cnt == PLL_LAST) begin
            st      <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            st  <= STABLE;
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            st      <= PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != EVT_MAX) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            st  <= RELEASE;
            cnt <= '0;
            idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == STG_LAST) begin
            ch_rst[idx] <= 1'b0;
            cnt         <= '0;
            if (idx == IDX_LAST) begin
              st        <= RUN;
              all_ready <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          all_ready <= 1'b1;
          ch_rst    <= '0;
        end
        default: begin
          st      <= PLL_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          ch_rst  <= '1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench: phase/elapsed-time reference model plus directed and random scenarios.
module tb_clk_rst_sequencer;
  localparam int N_CH = 3;
  localparam int PRC  = 3;
  localparam int LC   = 8;
  localparam int STG  = 4;
  localparam int TO   = 20;
  localparam int CW   = 2;

  logic          clk;
  logic          reset;
  logic          pll_locked;
  logic          sw_rst_req;
  logic          pll_rst;
  logic [N_CH-1:0] ch_rst;
  logic          all_ready;
  logic [2:0]    state;
  logic [CW-1:0] lock_loss_cnt;
  logic [CW-1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: phase (0..4), edges spent in phase, event counts, sync pipe
  int m_phase, m_t, m_ll, m_rc;
  bit m_s1, m_s2;

  clk_rst_sequencer #(
    .N_CH(N_CH), .PLL_RST_CYCLES(PRC), .LOCK_CYCLES(LC),
    .STAGGER(STG), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
    .pll_rst(pll_rst), .ch_rst(ch_rst), .all_ready(all_ready), .state(state),
    .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_ll = 0; m_rc = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge(input bit l, input bit sw);
    bit ls;
    ls = m_s2;
    if (sw && m_phase != 0) begin
      m_phase = 0; m_t = 0;
    end else if (!ls && (m_phase == 3 || m_phase == 4)) begin
      m_phase = 1; m_t = 0;
      if (m_ll < 3) m_ll++;
    end else begin
      case (m_phase)
        0: if (m_t == PRC - 1) begin m_phase = 1; m_t = 0; end else m_t++;
        1: if (ls) begin m_phase = 2; m_t = 0; end
           else if (m_t == TO - 1) begin m_phase = 0; m_t = 0; if (m_rc < 3) m_rc++; end
           else m_t++;
        2: if (!ls) begin m_phase = 1; m_t = 0; end
           else if (m_t == LC - 1) begin m_phase = 3; m_t = 0; end
           else m_t++;
        3: begin m_t++; if (m_t == N_CH * STG) begin m_phase = 4; m_t = 0; end end
        default: ;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = l;
  endtask

  function automatic logic [11:0] exp_vec();
    logic [2:0] ch;
    ch = 3'b111;
    if (m_phase == 4) ch = 3'b000;
    else if (m_phase == 3) ch = 3'(7 << (m_t / STG));
    return {m_phase == 0, ch, m_phase == 4, 3'(m_phase), 2'(m_ll), 2'(m_rc)};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {pll_rst, ch_rst, all_ready, state, lock_loss_cnt, retry_cnt};
  endfunction

  // called just after a falling edge; inputs settle well before the next rising edge
  task automatic step(input bit l, input bit sw);
    pll_locked = l;
    sw_rst_req = sw;
    model_edge(l, sw);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; pll_locked = 1'b0; sw_rst_req = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b1; sw_rst_req = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (pll_rst !== 1'b1 || ch_rst !== 3'b111 || all_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pll_rst=%b ch_rst=%b all_ready=%b expected 1 111 0", pll_rst, ch_rst, all_ready);
    end
    checks++;
    if (state !== 3'd0 || lock_loss_cnt !== 2'd0 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d ll=%0d rc=%0d expected 0 0 0", state, lock_loss_cnt, retry_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up();
    int e;
    apply_reset();
    e = 0;
    while (pll_rst === 1'b1 && e < 10) begin
      step(1, 0); e++;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL power_up_model: got %h expected %h", dut_vec(), exp_vec()); end
    end
    checks++;
    if (e != PRC) begin errors++; $display("FAIL power_up_pll_rst_width: got %0d edges expected %0d", e, PRC); end
    e = 0;
    while (state !== 3'd2 && e < 20) begin step(1, 0); e++; end
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL power_up_stable_timeout: got state %0d expected 2", state); end
    e = 0;
    while (ch_rst[0] === 1'b1 && e < 40) begin
      step(1, 0); e++;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL power_up_model: got %h expected %h", dut_vec(), exp_vec()); end
    end
    checks++;
    if (e != LC + STG || ch_rst !== 3'b110) begin
      errors++; $display("FAIL power_up_ch0_latency: got %0d edges ch_rst=%b expected %0d 110", e, ch_rst, LC + STG);
    end
    repeat (STG) step(1, 0);
    checks++;
    if (ch_rst !== 3'b100 || all_ready !== 1'b0) begin
      errors++; $display("FAIL power_up_ch1: got ch_rst=%b ready=%b expected 100 0", ch_rst, all_ready);
    end
    repeat (STG - 1) step(1, 0);
    checks++;
    if (ch_rst !== 3'b100 || all_ready !== 1'b0) begin
      errors++; $display("FAIL power_up_ch2_early: got ch_rst=%b ready=%b expected 100 0", ch_rst, all_ready);
    end
    step(1, 0);
    checks++;
    if (ch_rst !== 3'b000 || all_ready !== 1'b1 || state !== 3'd4 || lock_loss_cnt !== 2'd0 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL power_up_run: got ch_rst=%b ready=%b state=%0d ll=%0d rc=%0d expected 000 1 4 0 0",
                         ch_rst, all_ready, state, lock_loss_cnt, retry_cnt);
    end
  endtask

  task automatic test_no_lock();
    int last_rise, rises;
    logic prev;
    apply_reset();
    last_rise = 0; rises = 0; prev = 1'b1;
    for (int i = 1; i <= 4 * (PRC + TO) + 5; i++) begin
      step(0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL no_lock_model cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        if (rises > 0) begin
          checks++;
          if (i - last_rise != PRC + TO) begin errors++; $display("FAIL no_lock_period: got %0d expected %0d", i - last_rise, PRC + TO); end
        end
        last_rise = i; rises++;
      end
      prev = pll_rst;
    end
    checks++;
    if (retry_cnt !== 2'd3 || rises != 4 || ch_rst !== 3'b111) begin
      errors++; $display("FAIL no_lock_saturate: got rc=%0d pulses=%0d ch_rst=%b expected 3 4 111", retry_cnt, rises, ch_rst);
    end
  endtask

  task automatic test_stable_glitch();
    int e;
    apply_reset();
    e = 0;
    while (state !== 3'd2 && e < 20) begin step(1, 0); e++; end
    repeat (4) step(1, 0);
    repeat (3) begin
      step(0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL glitch_model: got %h expected %h", dut_vec(), exp_vec()); end
    end
    e = 0;
    while (state !== 3'd1 && e < 5) begin step(1, 0); e++; end
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL glitch_wait_lock: got state %0d expected 1", state); end
    e = 0;
    while (state !== 3'd2 && e < 10) begin step(1, 0); e++; end
    e = 0;
    while (ch_rst[0] === 1'b1 && e < 40) begin
      step(1, 0); e++;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL glitch_model: got %h expected %h", dut_vec(), exp_vec()); end
    end
    checks++;
    if (e != LC + STG || lock_loss_cnt !== 2'd0) begin
      errors++; $display("FAIL glitch_restart: got %0d edges ll=%0d expected %0d 0", e, lock_loss_cnt, LC + STG);
    end
  endtask

  task automatic test_run_loss();
    int e;
    bit pr_seen;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      e = 0;
      while (all_ready !== 1'b1 && e < 100) begin step(1, 0); e++; end
      checks++;
      if (all_ready !== 1'b1) begin errors++; $display("FAIL run_loss_reach_run %0d: got ready=%b expected 1", k, all_ready); end
      e = 0; pr_seen = 0;
      while (ch_rst !== 3'b111 && e < 6) begin
        step(0, 0); e++;
        if (pll_rst !== 1'b0) pr_seen = 1;
      end
      checks++;
      if (e > 3 || all_ready !== 1'b0 || pr_seen || lock_loss_cnt !== 2'((k > 3) ? 3 : k)) begin
        errors++; $display("FAIL run_loss %0d: got edges=%0d ready=%b pll_pulse=%b ll=%0d expected <=3 0 0 %0d",
                           k, e, all_ready, pr_seen, lock_loss_cnt, (k > 3) ? 3 : k);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL run_loss_model %0d: got %h expected %h", k, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_sw_collision();
    int e;
    logic [CW-1:0] ll0;
    apply_reset();
    e = 0;
    while (all_ready !== 1'b1 && e < 100) begin step(1, 0); e++; end
    ll0 = lock_loss_cnt;
    step(0, 0);
    step(0, 0);
    step(0, 1);
    checks++;
    if (state !== 3'd0 || pll_rst !== 1'b1 || ch_rst !== 3'b111 || lock_loss_cnt !== ll0) begin
      errors++; $display("FAIL sw_collision: got state=%0d pll_rst=%b ch_rst=%b ll=%0d expected 0 1 111 %0d",
                         state, pll_rst, ch_rst, lock_loss_cnt, ll0);
    end
    e = 0;
    while (pll_rst === 1'b1 && e < 10) begin step(1, 0); e++; end
    checks++;
    if (e != PRC || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL sw_pll_rst_width: got %0d edges vec %h expected %0d vec %h", e, dut_vec(), PRC, exp_vec());
    end
  endtask

  task automatic test_mid_release_reset();
    int e;
    apply_reset();
    e = 0;
    while (ch_rst !== 3'b110 && e < 100) begin step(1, 0); e++; end
    checks++;
    if (ch_rst !== 3'b110) begin errors++; $display("FAIL midrel_reach: got ch_rst=%b expected 110", ch_rst); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ch_rst !== 3'b111 || pll_rst !== 1'b1 || state !== 3'd0 || lock_loss_cnt !== 2'd0 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL midrel_async_reset: got ch_rst=%b pll_rst=%b state=%0d ll=%0d rc=%0d expected 111 1 0 0 0",
                         ch_rst, pll_rst, state, lock_loss_cnt, retry_cnt);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < PRC + 3 + LC + N_CH * STG + 2; i++) begin
      step(1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL midrel_restart cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (all_ready !== 1'b1) begin errors++; $display("FAIL midrel_run: got ready=%b expected 1", all_ready); end
  endtask

  task automatic test_random();
    int hold;
    bit l;
    apply_reset();
    hold = 0; l = 1;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        l = ($urandom_range(0, 9) < 7);
        hold = l ? $urandom_range(1, 60) : $urandom_range(1, 25);
      end
      hold--;
      step(l, $urandom_range(0, 199) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
    end
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; sw_rst_req = 1'b0;
    model_reset();
    test_reset();
    test_power_up();
    test_no_lock();
    test_stable_glitch();
    test_run_loss();
    test_sw_collision();
    test_mid_release_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
